uart_loop_fifo: RTL and testbench

//  Byte buffer and TX pacer between the UART receive path and the UART transmit path.
//  - Receive side: each rx_done_i pulse pushes one byte.
//  - Transmit side: bytes are popped and issued as single-cycle tx_en_o pulses, no faster than one per UART frame time.
//  - The transmit path has no busy output, so back-to-back received bytes are never lost to a busy transmitter.
//  - Sits in the loopback top between the receive path outputs and the transmit path inputs.

---
 rtl/uart_loop_fifo.sv | 139 +++++++++++++
 tb/tb_uart_loop_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_loop_fifo.sv
// Byte FIFO between the UART receive and transmit paths, with a pop FSM that issues
// one tx_en_o strobe per frame time so the transmitter never sees a byte while busy.
module uart_loop_fifo #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int FRAME_BITS   = 10,
  parameter int GUARD_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_done_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_en_o,
  output logic [ADDR_W:0]   fifo_cnt_o,
  output logic              fifo_full_o,
  output logic              fifo_empty_o,
  output logic              overflow_o,
  input  logic              overflow_clr_i
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam int BIT_CYC   = CLK_FREQ / BAUD;
  localparam int FRAME_CYC = BIT_CYC * FRAME_BITS + GUARD_CYCLES;
  localparam int PACE_W    = $clog2(FRAME_CYC);
  localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(FRAME_CYC - 2);
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_cnt;
  logic                r_full;
  logic                r_empty;
  logic                r_ovf;
  logic                r_tx_en;
  logic [DATA_W-1:0]   r_tx_data;
  logic [PACE_W-1:0]   r_pace;
  logic                w_push;
  logic                w_pop;
  logic                w_ovf_evt;
  logic [ADDR_W:0]     w_cnt_nxt;

  // Full is judged on the registered (pre-edge) flag, so a same-edge pop never rescues a byte.
  assign w_push    = rx_done_i & ~r_full;
  assign w_ovf_evt = rx_done_i & r_full;

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty) begin
          w_next = S_ISSUE;
          w_pop  = 1'b1;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_pace == PACE_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)
      w_cnt_nxt = r_cnt + (ADDR_W+1)'(1);
    else if (w_pop && !w_push)
      w_cnt_nxt = r_cnt - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Pace starts at the pop edge and counts through ISSUE and WAIT; one IDLE cycle closes the frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_pace <= '0;
    else if (w_pop)
      r_pace <= '0;
    else if (r_state != S_IDLE)
      r_pace <= r_pace + PACE_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (w_push)
      r_mem[r_wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
        r_tx_data <= r_mem[r_rd_ptr];
      end
      r_tx_en <= w_pop;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CNT_FULL);
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_ovf <= 1'b0;
    else if (w_ovf_evt)
      r_ovf <= 1'b1;
    else if (overflow_clr_i)
      r_ovf <= 1'b0;
  end

  assign tx_data_o    = r_tx_data;
  assign tx_en_o      = r_tx_en;
  assign fifo_cnt_o   = r_cnt;
  assign fifo_full_o  = r_full;
  assign fifo_empty_o = r_empty;
  assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Bench for uart_loop_fifo: queue-based reference model plus vector table and corner sequences.
module tb_uart_loop_fifo;
  localparam int F = 116;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] tx_data;
  logic       tx_en;
  logic [4:0] cnt;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       ovf_clr;

  uart_loop_fifo #(
    .DATA_W(8), .ADDR_W(4), .CLK_FREQ(1_000_000), .BAUD(100_000),
    .FRAME_BITS(10), .GUARD_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_done_i(rx_done),
    .tx_data_o(tx_data), .tx_en_o(tx_en), .fifo_cnt_o(cnt),
    .fifo_full_o(full), .fifo_empty_o(empty), .overflow_o(ovf),
    .overflow_clr_i(ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_t[$];

  // Reference model: byte queue, clocks since last emission, sticky flag, held output byte.
  logic [7:0] q[$];
  int         gap;
  logic       m_ovf;
  logic [7:0] m_data;
  logic       m_en;

  typedef struct {
    logic       done;
    logic [7:0] d;
    logic       clr;
    int         cnt;
    logic       en;
    logic [7:0] txd;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    gap    = F;
    m_ovf  = 1'b0;
    m_data = 8'h00;
    m_en   = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_en"}, tx_en, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_cnt"}, cnt, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  task automatic step(input logic done, input logic [7:0] d, input logic clr);
    bit full_pre, pop, push;
    @(negedge clk);
    rx_done = done;
    rx_data = d;
    ovf_clr = clr;
    full_pre = (q.size() == 16);
    if (gap < F) gap++;
    pop  = (q.size() > 0) && (gap >= F);
    push = done && !full_pre;
    m_en = 1'b0;
    if (pop) begin
      m_data = q.pop_front();
      m_en   = 1'b1;
      gap    = 0;
    end
    if (push) q.push_back(d);
    if (done && full_pre) m_ovf = 1'b1;
    else if (clr)         m_ovf = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (tx_en) pulse_t.push_back(cyc);
    chk("m_tx_en", tx_en, m_en);
    chk("m_tx_data", tx_data, m_data);
    chk("m_cnt", cnt, q.size());
    chk("m_full", full, q.size() == 16);
    chk("m_empty", empty, q.size() == 0);
    chk("m_ovf", ovf, m_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int n_before;
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h3C, 1'b1, 1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; ovf_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    // Single byte plus a second byte that must wait out the frame.
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].done, tbl[i].d, tbl[i].clr);
      chk("tbl_cnt", cnt, tbl[i].cnt);
      chk("tbl_tx_en", tx_en, tbl[i].en);
      chk("tbl_tx_data", tx_data, tbl[i].txd);
      chk("tbl_full", full, tbl[i].full);
      chk("tbl_empty", empty, tbl[i].empty);
      chk("tbl_ovf", ovf, tbl[i].ovf);
    end

    // Reset mid-WAIT with 3 bytes queued.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h12, 1'b0);
    idle(20);
    chk("pre_rst_cnt", cnt, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    n_before = pulse_t.size();
    idle(300);
    chk("post_rst_no_tx", pulse_t.size(), n_before);

    // Burst of three, exact frame spacing.
    pulse_t.delete();
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    idle(400);
    chk("burst_pulses", pulse_t.size(), 3);
    if (pulse_t.size() == 3) begin
      chk("burst_gap1", pulse_t[1] - pulse_t[0], F);
      chk("burst_gap2", pulse_t[2] - pulse_t[1], F);
    end
    chk("burst_last_data", tx_data, 8'h03);

    // Fill to 16 while pacing, 17th byte dropped, then clear the sticky flag.
    step(1'b1, 8'h70, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    chk("full_cnt", cnt, 16);
    chk("full_flag", full, 1);
    chk("full_ovf", ovf, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("ovf_cleared", ovf, 0);
    idle(2100);
    chk("drain_last_data", tx_data, 8'h8F);

    // Push and pop on the same edge at occupancy 5.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    chk("pp_pre_cnt", cnt, 5);
    while (!(q.size() > 0 && gap + 1 >= F)) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h99, 1'b0);
    chk("pp_cnt", cnt, 5);
    chk("pp_tx_en", tx_en, 1);
    chk("pp_data", tx_data, 8'h51);
    idle(900);

    // Stream 40 bytes, pointers wrap twice.
    pulse_t.delete();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(i), 1'b0);
      idle(119);
    end
    chk("wrap_pulses", pulse_t.size(), 40);
    chk("wrap_last", tx_data, 8'h27);
    chk("wrap_ovf", ovf, 0);

    // Randomised traffic: alternating sparse and bursty segments, occasional clears.
    for (int seg = 0; seg < 6; seg++) begin
      int p;
      p = (seg % 2 == 0) ? 2 : 40;
      for (int i = 0; i < 500; i++)
        step($urandom_range(0, 99) < p, 8'($urandom), $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
